// File: rtl/op_sequencer_if.sv
// op_sequencer_if: host command/page-data and controller-side signals of the op sequencer.
interface op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] operation;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        ctl_enable;
  logic        busy;
  logic        done;
  logic        err;
  modport slave (
    input  cmd_valid, cmd_word, wr_valid, wr_data, out_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, operation, in_data, ctl_enable, busy, done, err
  );
  modport master (
    output cmd_valid, cmd_word, wr_valid, wr_data, out_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, operation, in_data, ctl_enable, busy, done, err
  );
endinterface

// File: rtl/op_sequencer.sv
// op_sequencer: holds each controller opcode for its required duration, streams page data, captures read-back.
module op_sequencer #(
  parameter int PAGE_WORDS  = 64,
  parameter int MULT_CYCLES = 96,
  parameter int RD_LAT      = 1,
  parameter int IDLE_GAP    = 1
) (
  input logic clk,
  input logic reset,
  op_sequencer_if.slave s
);
  localparam int M1   = MULT_CYCLES > PAGE_WORDS ? MULT_CYCLES : PAGE_WORDS;
  localparam int CMAX = M1 > IDLE_GAP ? M1 : IDLE_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [RD_LAT-1:0] TOP = RD_LAT'(1) << (RD_LAT - 1);
  typedef enum logic [2:0] {IDLE, MULT, WRITE, READ, DRAIN, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [RD_LAT-1:0] sr, nxt;
  logic [31:0] operation, rd_data;
  logic rd_valid, done, err, last;
  logic [3:0] op;
  // nxt[RD_LAT-1] marks the cycle whose out_data belongs to a read issued RD_LAT-1 cycles ago
  always_comb begin
    op = s.cmd_word[3:0];
    nxt = RD_LAT'({sr, state == READ});
    last = (state == MULT && cnt == CW'(MULT_CYCLES - 1)) ||
           (state == WRITE && s.wr_valid && cnt == CW'(PAGE_WORDS - 1)) ||
           (state == DRAIN && (sr & ~TOP) == '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      operation <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      sr <= nxt;
      rd_valid <= nxt[RD_LAT-1];
      if (nxt[RD_LAT-1]) rd_data <= s.out_data;
      done <= 1'b0;
      err <= 1'b0;
      cnt <= cnt + CW'(1);
      if (state == IDLE) begin
        cnt <= '0;
        if (s.cmd_valid) begin
          state <= op == 4'd1 ? MULT : op == 4'd2 ? WRITE : op == 4'd3 ? READ : GAP;
          operation <= (op == 4'd0 || op > 4'd3) ? '0 : s.cmd_word;
          done <= op == 4'd0;
          err <= op > 4'd3;
        end
      end else if (last) begin
        state <= GAP;
        cnt <= '0;
        operation <= '0;
        done <= 1'b1;
      end else if (state == WRITE) begin
        cnt <= cnt + CW'(s.wr_valid);
      end else if (state == READ && cnt == CW'(PAGE_WORDS - 1)) begin
        state <= DRAIN;
        cnt <= '0;
        operation <= '0;
      end else if (state == GAP && cnt == CW'(IDLE_GAP - 1)) begin
        state <= IDLE;
        cnt <= '0;
      end
    end
  end
  assign s.cmd_ready  = state == IDLE;
  assign s.busy       = state != IDLE;
  assign s.wr_ready   = state == WRITE;
  assign s.ctl_enable = state == WRITE ? s.wr_valid : 1'b1;
  assign s.in_data    = state == WRITE ? s.wr_data : '0;
  assign s.operation  = operation;
  assign s.rd_data    = rd_data;
  assign s.rd_valid   = rd_valid;
  assign s.done       = done;
  assign s.err        = err;
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed checks of the op sequencer against hand-computed timelines.
module tb_op_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] rcnt;
  int n_chk = 0;
  int n_pass = 0;
  op_sequencer_if bus();
  op_sequencer dut (.clk(clk), .reset(reset), .s(bus.slave));
  always #5 clk = ~clk;
  // controller model: read address counts consecutive opcode-3 cycles
  always_ff @(posedge clk) rcnt <= (bus.operation[3:0] == 4'd3) ? rcnt + 32'd1 : 32'd0;
  assign bus.out_data = 32'h100 + rcnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic [31:0] w);
    bus.cmd_valid = 1'b1;
    bus.cmd_word = w;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    int bad, w, nlow, np, first, lastp, done_at, rises, run, maxrun, zeros, ndone;
    logic [31:0] prev;
    bus.cmd_valid = 1'b0;
    bus.cmd_word = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    rcnt = '0;
    repeat (3) tick();
    chk("rst_operation", bus.operation, 32'd0);
    chk("rst_flags", {bus.rd_valid, bus.done, bus.err, bus.busy, bus.cmd_ready, bus.wr_ready, bus.ctl_enable},
        7'b0000101);
    chk("rst_data", {bus.in_data ^ bus.rd_data}, 32'd0);
    reset = 1'b0;
    tick();
    // multiply: 96 cycles of opcode 1, then done on the gap cycle
    issue(32'h1);
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      if (bus.operation !== 32'd1 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b0) bad++;
      tick();
    end
    chk("mult_hold", bad, 0);
    chk("mult_gap", {bus.operation[0], bus.done, bus.cmd_ready, bus.busy}, 4'b0101);
    tick();
    chk("mult_ready", {bus.done, bus.cmd_ready, bus.busy}, 3'b010);
    // write page with stalls on write cycles 5 and 20
    issue(32'h12);
    bad = 0; w = 0; nlow = 0;
    for (int j = 0; j < 66; j++) begin
      bus.wr_valid = !(j == 5 || j == 20);
      bus.wr_data = w;
      #1;
      if (bus.wr_ready !== 1'b1 || bus.in_data !== w || bus.ctl_enable !== bus.wr_valid ||
          bus.operation !== 32'h12 || bus.done !== 1'b0) bad++;
      if (!bus.ctl_enable) nlow++;
      w += int'(bus.wr_valid);
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("write_cycles", bad, 0);
    chk("write_words", w, 64);
    chk("write_stalls", nlow, 2);
    chk("write_gap", {bus.done, bus.wr_ready, bus.ctl_enable, bus.operation[7:0]}, {3'b101, 8'h00});
    chk("write_in_data", bus.in_data, 32'd0);
    tick();
    // read page: pulses on acceptance+2 .. +65, done at +66
    issue(32'h13);
    np = 0; bad = 0; first = -1; lastp = -1; done_at = -1;
    for (int c = 1; c <= 80; c++) begin
      if (bus.rd_valid) begin
        if (bus.rd_data !== 32'h100 + np) bad++;
        if (first < 0) first = c;
        lastp = c;
        np++;
      end
      if (bus.done && done_at < 0) done_at = c;
      tick();
    end
    chk("read_count", np, 64);
    chk("read_data", bad, 0);
    chk("read_first", first, 2);
    chk("read_last", lastp, 65);
    chk("read_done", done_at, 66);
    // invalid opcode
    issue(32'h7);
    chk("inv_pulse", {bus.err, bus.done, bus.busy, bus.cmd_ready}, 4'b1010);
    chk("inv_operation", bus.operation, 32'd0);
    tick();
    chk("inv_ready", {bus.err, bus.done, bus.cmd_ready}, 3'b001);
    // opcode 0 completes straight through the gap
    issue(32'h0);
    chk("nop_done", {bus.done, bus.err, bus.operation[3:0]}, 6'b100000);
    tick();
    // back-to-back multiplies with cmd_valid held
    bus.cmd_valid = 1'b1;
    bus.cmd_word = 32'h1;
    tick();
    prev = '0; rises = 0; run = 0; maxrun = 0; zeros = 0; ndone = 0;
    for (int i = 0; i < 196; i++) begin
      if (bus.operation != 0 && prev == 0) rises++;
      run = (bus.operation != 0) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (bus.operation == 0) zeros++;
      if (bus.done) ndone++;
      prev = bus.operation;
      if (i == 195) bus.cmd_valid = 1'b0;
      tick();
    end
    chk("b2b_rises", rises, 2);
    chk("b2b_maxrun", maxrun, 96);
    chk("b2b_zeros", zeros, 4);
    chk("b2b_done", ndone, 2);
    tick();
    // reset at read cycle 30
    issue(32'h13);
    repeat (30) tick();
    chk("rr_active", {bus.operation[7:0], bus.rd_valid}, {8'h13, 1'b1});
    reset = 1'b1;
    tick();
    chk("rr_cleared", {bus.operation[7:0], bus.rd_valid, bus.busy, bus.cmd_ready}, {8'h00, 3'b000, 1'b1});
    reset = 1'b0;
    np = 0; ndone = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.rd_valid) np++;
      if (bus.done) ndone++;
      tick();
    end
    chk("rr_quiet", {np[15:0], ndone[15:0]}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
